sprite_line_sched: RTL and testbench

SPRITE_LINE_SCHED -- requirements
Module: sprite_line_sched

---
 rtl/sprite_line_sched_pkg.sv | 28 ++
 rtl/sprite_line_sched_hit.sv | 28 ++
 rtl/sprite_line_sched.sv | 217 +++++++++++++++++++++
 tb/tb_sprite_line_sched.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_line_sched_pkg.sv
// Shared sprite parameters, FSM state encoding and mem_addr layout.
// Imported by sprite_row_hit and sprite_line_sched.
package sprite_line_sched_pkg;

    localparam int N_SPR_DEF  = 4;
    localparam int SPR_H_DEF  = 16;
    localparam int BUDGET_DEF = 160;

    localparam int Y_W    = 10;
    localparam int SLOT_W = 2;
    localparam int ROW_W  = 4;
    localparam int ADDR_W = SLOT_W + ROW_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FETCH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [ADDR_W-1:0] mk_addr(
        input logic [SLOT_W-1:0] slot,
        input logic [ROW_W-1:0]  row
    );
        return {slot, row};
    endfunction

endpackage

// File: rtl/sprite_line_sched_hit.sv
// sprite_row_hit: vertical hit test and row index for one sprite slot.
// In: v_pos, spr_y, spr_en. Out: hit, row (line within the sprite).
module sprite_row_hit
    import sprite_line_sched_pkg::*;
#(
    parameter int SPR_H = SPR_H_DEF
) (
    input  logic [Y_W-1:0]   v_pos,
    input  logic [Y_W-1:0]   spr_y,
    input  logic             spr_en,
    output logic             hit,
    output logic [ROW_W-1:0] row
);

    localparam logic [Y_W-1:0] H_LIM = Y_W'(SPR_H);

    logic [Y_W-1:0] diff;
    logic           above;
    logic           in_h;

    // diff wraps when v_pos < spr_y; the >= guard rejects that case.
    assign diff  = v_pos - spr_y;
    assign above = (v_pos >= spr_y);
    assign in_h  = (diff < H_LIM);
    assign hit   = spr_en & above & in_h;
    assign row   = diff[ROW_W-1:0];

endmodule

// File: rtl/sprite_line_sched.sv
// sprite_line_sched: per-scanline sprite sweep that fetches one row
// per visible slot within a pixel_clk budget.
// In: clk, rst (sync, low), pixel_clk, h_sync, v_pos, spr_en, spr_y,
//     mem_ack. Out: mem_req, mem_addr, line_load, active_mask, busy,
//     line_done, overrun.
module sprite_line_sched
    import sprite_line_sched_pkg::*;
#(
    parameter int N_SPR  = N_SPR_DEF,
    parameter int SPR_H  = SPR_H_DEF,
    parameter int BUDGET = BUDGET_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pixel_clk,
    input  logic                 h_sync,
    input  logic [Y_W-1:0]       v_pos,
    input  logic [N_SPR-1:0]     spr_en,
    input  logic [Y_W*N_SPR-1:0] spr_y,
    output logic                 mem_req,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic                 mem_ack,
    output logic [N_SPR-1:0]     line_load,
    output logic [N_SPR-1:0]     active_mask,
    output logic                 busy,
    output logic                 line_done,
    output logic                 overrun
);

    // DONE adds one more count after expiry, so size for BUDGET+1.
    localparam int CNT_W = $clog2(BUDGET + 2);

    localparam logic [SLOT_W-1:0] LAST =
        SLOT_W'(N_SPR - 1);
    localparam logic [CNT_W-1:0] EXP_AT =
        CNT_W'(BUDGET - 1);

    state_e state_q;
    state_e state_d;

    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_d;
    logic [ROW_W-1:0]  row_q;
    logic [ROW_W-1:0]  row_d;
    logic [CNT_W-1:0]  budget_q;
    logic [CNT_W-1:0]  budget_d;
    logic [N_SPR-1:0]  active_q;
    logic [N_SPR-1:0]  active_d;
    logic              overrun_q;
    logic              overrun_d;

    logic [N_SPR-1:0] slot_oh;
    logic [Y_W-1:0]   cur_y;
    logic             cur_en;
    logic             cur_hit;
    logic [ROW_W-1:0] cur_row;

    logic in_sweep;
    logic accept_hs;
    logic expire;
    logic ack_ok;
    logic last_slot;

    always_comb begin
        slot_oh = '0;
        for (int i = 0; i < N_SPR; i++) begin
            slot_oh[i] = (slot_q == SLOT_W'(i));
        end
    end

    always_comb begin
        cur_y  = '0;
        cur_en = 1'b0;
        for (int i = 0; i < N_SPR; i++) begin
            if (slot_oh[i]) begin
                cur_y  = spr_y[Y_W*i +: Y_W];
                cur_en = spr_en[i];
            end
        end
    end

    sprite_row_hit #(
        .SPR_H (SPR_H)
    ) u_hit (
        .v_pos  (v_pos),
        .spr_y  (cur_y),
        .spr_en (cur_en),
        .hit    (cur_hit),
        .row    (cur_row)
    );

    assign in_sweep  = (state_q == ST_SCAN) ||
                       (state_q == ST_FETCH);
    assign last_slot = (slot_q == LAST);

    // h_sync in DONE is ignored; anywhere else it (re)starts a sweep.
    assign accept_hs = h_sync && (state_q != ST_DONE);

    // Expiry is the strobe that would bring the count to BUDGET.
    // A restart request outranks expiry, and expiry outranks an ack.
    assign expire = in_sweep && !h_sync && pixel_clk &&
                    (budget_q == EXP_AT);
    assign ack_ok = (state_q == ST_FETCH) && mem_ack &&
                    !h_sync && !expire;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        row_d   = row_q;
        unique case (state_q)
            ST_IDLE: begin
                if (h_sync) begin
                    state_d = ST_SCAN;
                    slot_d  = '0;
                end
            end
            ST_SCAN: begin
                if (h_sync) begin
                    state_d = ST_SCAN;
                    slot_d  = '0;
                end else if (expire) begin
                    state_d = ST_DONE;
                end else if (cur_hit) begin
                    state_d = ST_FETCH;
                    row_d   = cur_row;
                end else if (last_slot) begin
                    state_d = ST_DONE;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            ST_FETCH: begin
                if (h_sync) begin
                    state_d = ST_SCAN;
                    slot_d  = '0;
                end else if (expire) begin
                    state_d = ST_DONE;
                end else if (mem_ack) begin
                    if (last_slot) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SCAN;
                        slot_d  = slot_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                slot_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                slot_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            budget_q  <= '0;
            active_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            budget_q  <= budget_d;
            active_q  <= active_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        budget_d  = budget_q;
        active_d  = active_q;
        overrun_d = overrun_q;
        if (accept_hs) begin
            budget_d  = '0;
            active_d  = '0;
            overrun_d = 1'b0;
        end else begin
            if ((state_q != ST_IDLE) && pixel_clk) begin
                budget_d = budget_q + 1'b1;
            end
            if (expire) begin
                overrun_d = 1'b1;
            end
            if (ack_ok) begin
                active_d = active_q | slot_oh;
            end
        end
    end

    // The rst term keeps the combinational strobe quiet during reset.
    always_comb begin
        busy        = (state_q != ST_IDLE);
        mem_req     = (state_q == ST_FETCH);
        mem_addr    = '0;
        if (mem_req) begin
            mem_addr = mk_addr(slot_q, row_q);
        end
        line_load   = (rst && ack_ok) ? slot_oh : '0;
        line_done   = (state_q == ST_DONE);
        active_mask = active_q;
        overrun     = overrun_q;
    end

endmodule

// File: tb/tb_sprite_line_sched.sv
// Scoreboard bench for sprite_line_sched: directed line scenarios and
// randomized lines checked against a per-line reference model.
module tb_sprite_line_sched;

    localparam int NS = 4;
    localparam int SH = 16;
    localparam int BG = 160;

    logic        clk = 1'b0;
    logic        rst;
    logic        pixel_clk = 1'b0;
    logic        h_sync;
    logic [9:0]  v_pos;
    logic [3:0]  spr_en;
    logic [39:0] spr_y;
    logic        mem_req;
    logic [5:0]  mem_addr;
    logic        mem_ack = 1'b0;
    logic [3:0]  line_load;
    logic [3:0]  active_mask;
    logic        busy;
    logic        line_done;
    logic        overrun;

    always #5 clk = ~clk;

    sprite_line_sched dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_clk   (pixel_clk),
        .h_sync      (h_sync),
        .v_pos       (v_pos),
        .spr_en      (spr_en),
        .spr_y       (spr_y),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .line_load   (line_load),
        .active_mask (active_mask),
        .busy        (busy),
        .line_done   (line_done),
        .overrun     (overrun)
    );

    typedef struct packed {
        logic [3:0] mask;
        logic       ovr;
    } done_t;

    logic [5:0] exp_addr[$];
    done_t      exp_done[$];

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int done_lat = 0;
    int lat      = 0;
    int load_cnt = 0;
    int req_cnt  = 0;

    int ack_delay  = -1;
    int acks_left  = -1;
    bit pix_always = 1'b0;
    int pix_pct    = 12;
    bit stray_en   = 1'b1;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    // Memory responder and pixel strobe source.
    bit req_seen = 1'b0;
    int cnt = 0;
    always @(negedge clk) begin
        if (pix_always) pixel_clk = 1'b1;
        else pixel_clk = ($urandom_range(0, 99) < pix_pct);
        if (mem_req && rst) begin
            if (!req_seen) begin
                req_seen = 1'b1;
                if (ack_delay < 0) cnt = $urandom_range(0, 4);
                else cnt = ack_delay;
            end
            if (acks_left != 0 && cnt == 0) begin
                mem_ack  = 1'b1;
                req_seen = 1'b0;
                if (acks_left > 0) acks_left--;
            end else begin
                mem_ack = 1'b0;
                if (cnt > 0) cnt--;
            end
        end else begin
            req_seen = 1'b0;
            mem_ack  = stray_en && ($urandom_range(0, 3) == 0);
        end
    end

    // Monitor: compares DUT outputs against the scoreboard queues.
    logic       prev_req  = 1'b0;
    logic [5:0] prev_addr = '0;
    logic [5:0] mon_a;
    logic [3:0] mon_ll;
    done_t      mon_d;
    always @(negedge clk) begin
        #3;
        if (!rst) begin
            prev_req = 1'b0;
            lat = 0;
        end else begin
            lat = busy ? lat + 1 : 0;
            if (mem_req && !prev_req) begin
                req_cnt++;
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("FAIL req_addr: req %0h, none expected",
                             mem_addr);
                end else if (mem_addr !== exp_addr[0]) begin
                    errors++;
                    $display("FAIL req_addr: got %0h expected %0h",
                             mem_addr, exp_addr[0]);
                end
            end
            if (mem_req && prev_req)
                chk("addr_stable", 32'(mem_addr), 32'(prev_addr));
            if (line_load != 4'b0000) begin
                load_cnt++;
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("FAIL load: got %b, none expected",
                             line_load);
                end else begin
                    mon_a  = exp_addr.pop_front();
                    mon_ll = 4'b0001 << mon_a[5:4];
                    if (line_load !== mon_ll ||
                        mem_addr !== mon_a) begin
                        errors++;
                        $display("FAIL load: got %b/%0h expected %b/%0h",
                                 line_load, mem_addr, mon_ll, mon_a);
                    end
                end
            end
            if (line_done) begin
                done_lat = lat;
                done_cnt++;
                checks++;
                if (exp_done.size() == 0) begin
                    errors++;
                    $display("FAIL done: pulse with none expected");
                end else begin
                    mon_d = exp_done.pop_front();
                    if (active_mask !== mon_d.mask ||
                        overrun !== mon_d.ovr ||
                        (!mon_d.ovr && exp_addr.size() != 0)) begin
                        errors++;
                        $display("FAIL done: got %b/%b expected %b/%b left %0d",
                                 active_mask, overrun,
                                 mon_d.mask, mon_d.ovr, exp_addr.size());
                    end
                end
            end
            prev_req  = mem_req;
            prev_addr = mem_addr;
        end
    end

    task automatic set_slots(input logic [3:0] en,
                             input int y0, input int y1,
                             input int y2, input int y3,
                             input int v);
        spr_en = en;
        spr_y  = {10'(y3), 10'(y2), 10'(y1), 10'(y0)};
        v_pos  = 10'(v);
    endtask

    // Reference: a slot is fetched when enabled and v in [y, y+SH).
    task automatic expect_line();
        int    v;
        int    y;
        done_t d;
        d.mask = 4'b0000;
        d.ovr  = 1'b0;
        v = int'(v_pos);
        for (int i = 0; i < NS; i++) begin
            y = int'(spr_y[10*i +: 10]);
            if (spr_en[i] && v >= y && (v - y) < SH) begin
                exp_addr.push_back(6'(i * 16 + (v - y)));
                d.mask[i] = 1'b1;
            end
        end
        exp_done.push_back(d);
    endtask

    task automatic pulse_hsync(input int w);
        @(negedge clk);
        h_sync = 1'b1;
        repeat (w) @(negedge clk);
        h_sync = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int limit);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done_seen"}, 32'(done_cnt != start), 32'd1);
    endtask

    task automatic wait_req(input string nm, input logic [5:0] a);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #4;
            n++;
        end while (!(mem_req && mem_addr == a) && n < 100);
        chk({nm, "_req"}, 32'(mem_req && mem_addr == a), 32'd1);
    endtask

    int    l0;
    int    d0;
    int    r0;
    int    v;
    int    yy[4];
    done_t dd;

    initial begin
        rst    = 1'b0;
        h_sync = 1'b0;
        v_pos  = '0;
        spr_en = '0;
        spr_y  = '0;
        repeat (3) @(negedge clk);
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_load", 32'(line_load), 32'd0);
        chk("rst_mask", 32'(active_mask), 32'd0);
        chk("rst_done", 32'(line_done), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single slot, ack three cycles after the request.
        ack_delay = 3;
        set_slots(4'b0001, 100, 0, 0, 0, 105);
        l0 = load_cnt;
        d0 = done_cnt;
        expect_line();
        pulse_hsync(1);
        wait_done("one", 60);
        repeat (3) @(negedge clk);
        #3;
        chk("one_loads", 32'(load_cnt - l0), 32'd1);
        chk("one_mask", 32'(active_mask), 32'h1);
        chk("one_pulses", 32'(done_cnt - d0), 32'd1);
        ack_delay = -1;

        // All four slots on their last row.
        set_slots(4'b1111, 200, 200, 200, 200, 215);
        l0 = load_cnt;
        expect_line();
        pulse_hsync(1);
        wait_done("four", 80);
        #3;
        chk("four_loads", 32'(load_cnt - l0), 32'd4);
        chk("four_mask", 32'(active_mask), 32'hf);

        // No hits: below-top wrap cases and one row past the bottom.
        set_slots(4'b1111, 600, 1020, 1000, 6, 5);
        r0 = req_cnt;
        expect_line();
        pulse_hsync(1);
        wait_done("wrap", 40);
        chk("wrap_lat", 32'(done_lat), 32'(NS + 1));
        chk("wrap_reqs", 32'(req_cnt - r0), 32'd0);
        set_slots(4'b1111, 100, 100, 100, 100, 116);
        expect_line();
        pulse_hsync(1);
        wait_done("below", 40);
        chk("below_lat", 32'(done_lat), 32'(NS + 1));
        chk("below_reqs", 32'(req_cnt - r0), 32'd0);
        set_slots(4'b1111, 100, 100, 100, 101, 116);
        expect_line();
        pulse_hsync(1);
        wait_done("edge", 40);
        #3;
        chk("edge_mask", 32'(active_mask), 32'h8);

        // Budget expiry with the ack withheld.
        pix_always = 1'b1;
        acks_left  = 0;
        set_slots(4'b0001, 100, 0, 0, 0, 105);
        l0 = load_cnt;
        exp_addr.push_back(6'h05);
        dd.mask = 4'b0000;
        dd.ovr  = 1'b1;
        exp_done.push_back(dd);
        pulse_hsync(1);
        wait_done("ovr", 400);
        chk("ovr_lat", 32'(done_lat), 32'(BG + 1));
        chk("ovr_loads", 32'(load_cnt - l0), 32'd0);
        exp_addr.delete();
        repeat (5) @(negedge clk);
        #3;
        chk("ovr_sticky", 32'(overrun), 32'd1);
        chk("ovr_req_low", 32'(mem_req), 32'd0);
        pix_always = 1'b0;
        acks_left  = -1;
        set_slots(4'b0000, 0, 0, 0, 0, 0);
        expect_line();
        pulse_hsync(1);
        #3;
        chk("ovr_cleared", 32'(overrun), 32'd0);
        chk("ovr_busy", 32'(busy), 32'd1);
        wait_done("ovr2", 40);

        // Reset while slot 1 is waiting on memory.
        acks_left = 1;
        set_slots(4'b0011, 100, 100, 0, 0, 105);
        exp_addr.push_back(6'h05);
        exp_addr.push_back(6'h15);
        pulse_hsync(1);
        wait_req("rstf", 6'h15);
        chk("rstf_pre_mask", 32'(active_mask), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        exp_addr.delete();
        exp_done.delete();
        #3;
        chk("rstf_load", 32'(line_load), 32'd0);
        @(negedge clk);
        #3;
        chk("rstf_busy", 32'(busy), 32'd0);
        chk("rstf_req", 32'(mem_req), 32'd0);
        chk("rstf_addr", 32'(mem_addr), 32'd0);
        chk("rstf_mask", 32'(active_mask), 32'd0);
        chk("rstf_done", 32'(line_done), 32'd0);
        chk("rstf_ovr", 32'(overrun), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // h_sync while slot 1 is waiting on memory.
        acks_left = 1;
        d0 = done_cnt;
        exp_addr.push_back(6'h05);
        exp_addr.push_back(6'h15);
        pulse_hsync(1);
        wait_req("abort", 6'h15);
        @(negedge clk);
        h_sync = 1'b1;
        exp_addr.delete();
        expect_line();
        @(negedge clk);
        h_sync = 1'b0;
        acks_left = -1;
        #3;
        chk("abort_mask", 32'(active_mask), 32'h0);
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_nodone", 32'(done_cnt - d0), 32'd0);
        wait_done("abort", 80);
        #3;
        chk("abort_final", 32'(active_mask), 32'h3);
        chk("abort_pulses", 32'(done_cnt - d0), 32'd1);

        // Randomized lines.
        for (int t = 0; t < 40; t++) begin
            v = $urandom_range(0, 1023);
            for (int i = 0; i < NS; i++) begin
                if ($urandom_range(0, 1) == 1)
                    yy[i] = (v - $urandom_range(0, 20) + 1024) % 1024;
                else
                    yy[i] = $urandom_range(0, 1023);
            end
            set_slots(4'($urandom_range(0, 15)),
                      yy[0], yy[1], yy[2], yy[3], v);
            expect_line();
            pulse_hsync($urandom_range(1, 2));
            wait_done("rand", 200);
        end

        repeat (3) @(negedge clk);
        chk("end_addr_q", 32'(exp_addr.size()), 32'd0);
        chk("end_done_q", 32'(exp_done.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

endmodule
